phys_regfile_ckpt: RTL and testbench

- Parametrised physical register file for the out-of-order core.
- Holds per-register data and ready (valid) bits, written by any number of functional units and cleared by any number of commit lanes.
- Holds the speculative flag register. FUs write it in execute; a circular checkpoint buffer snapshots it at branch dispatch and restores it on mispredict flush.
- Sits between execute/writeback, issue (operand read) and commit (ROB).

---
 rtl/phys_regfile_ckpt.sv | 145 ++++++++++++++
 tb/tb_phys_regfile_ckpt.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/phys_regfile_ckpt.sv
// Physical register file with ready bits, speculative flag register and circular flag checkpoints.
// Optional macro ARCH_STATE_FWD_EN: read ports bypass same-cycle FU writes.
module phys_regfile_ckpt #(
   parameter int unsigned NUM_PHYS_REG = 128,
   parameter int unsigned NUM_ARCH_REG = 16,
   parameter int unsigned WORD_W       = 16,
   parameter int unsigned NUM_WR       = 4,
   parameter int unsigned NUM_RD       = 4,
   parameter int unsigned NUM_CLR      = 2,
   parameter int unsigned NUM_FLAGS    = 4,
   parameter int unsigned CKPT_DEPTH   = 4
) (
   input  logic                                         clk_i,
   input  logic                                         reset_i,
   input  logic [NUM_WR-1:0]                            wr_v_i,
   input  logic [NUM_WR*$clog2(NUM_PHYS_REG)-1:0]       wr_addr_i,
   input  logic [NUM_WR*WORD_W-1:0]                     wr_data_i,
   input  logic [NUM_WR-1:0]                            flag_w_v_i,
   input  logic [NUM_WR*2*NUM_FLAGS-1:0]                flag_w_i,
   input  logic [NUM_CLR-1:0]                           clr_v_i,
   input  logic [NUM_CLR*$clog2(NUM_PHYS_REG)-1:0]      clr_addr_i,
   input  logic [NUM_RD*$clog2(NUM_PHYS_REG)-1:0]       rd_addr_i,
   output logic [NUM_RD-1:0]                            rd_valid_o,
   output logic [NUM_RD*WORD_W-1:0]                     rd_data_o,
   output logic [NUM_FLAGS-1:0]                         flag_o,
   input  logic                                         ckpt_push_i,
   output logic [$clog2(CKPT_DEPTH)-1:0]                ckpt_id_o,
   input  logic                                         ckpt_pop_i,
   input  logic                                         restore_i,
   input  logic [$clog2(CKPT_DEPTH)-1:0]                restore_id_i,
   output logic                                         ckpt_full_o,
   output logic                                         ckpt_empty_o
);

   localparam int unsigned AW = $clog2(NUM_PHYS_REG);
   localparam int unsigned IW = $clog2(CKPT_DEPTH);
   localparam int unsigned CW = IW + 1;
   localparam int unsigned FW = 2 * NUM_FLAGS;

   logic [WORD_W-1:0]       data_q [NUM_PHYS_REG];
   logic [NUM_PHYS_REG-1:0] valid_q;
   logic [NUM_FLAGS-1:0]    flag_q;
   logic [NUM_FLAGS-1:0]    flag_next;
   logic [NUM_FLAGS-1:0]    ckpt_q [CKPT_DEPTH];
   logic [IW-1:0]           head_q;
   logic [IW-1:0]           tail_q;
   logic [CW-1:0]           count_q;
   logic                    full;
   logic                    empty;
   logic                    push_ok;
   logic                    pop_ok;

   // Register data and ready bits; later ports override earlier ones, clears override writes.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int unsigned r = 0; r < NUM_PHYS_REG; r++) begin
            data_q[r]  <= '0;
            valid_q[r] <= (r < NUM_ARCH_REG);
         end
      end else begin
         for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_v_i[w]) begin
               data_q[wr_addr_i[w*AW +: AW]]  <= wr_data_i[w*WORD_W +: WORD_W];
               valid_q[wr_addr_i[w*AW +: AW]] <= 1'b1;
            end
         end
         for (int unsigned c = 0; c < NUM_CLR; c++) begin
            if (clr_v_i[c]) begin
               valid_q[clr_addr_i[c*AW +: AW]] <= 1'b0;
            end
         end
      end
   end

   // Operand reads from registered state, optionally bypassing same-cycle writes.
   always_comb begin
      rd_valid_o = '0;
      rd_data_o  = '0;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         rd_valid_o[p]                  = valid_q[rd_addr_i[p*AW +: AW]];
         rd_data_o[p*WORD_W +: WORD_W]  = data_q[rd_addr_i[p*AW +: AW]];
`ifdef ARCH_STATE_FWD_EN
         for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_v_i[w] && (wr_addr_i[w*AW +: AW] == rd_addr_i[p*AW +: AW])) begin
               rd_valid_o[p]                 = 1'b1;
               rd_data_o[p*WORD_W +: WORD_W] = wr_data_i[w*WORD_W +: WORD_W];
            end
         end
`endif
      end
   end

   // Masked flag merge in ascending port order; each entry is {mask, value}.
   always_comb begin
      flag_next = flag_q;
      for (int unsigned w = 0; w < NUM_WR; w++) begin
         if (flag_w_v_i[w]) begin
            flag_next = (flag_w_i[w*FW + NUM_FLAGS +: NUM_FLAGS] & flag_w_i[w*FW +: NUM_FLAGS])
                      | (~flag_w_i[w*FW + NUM_FLAGS +: NUM_FLAGS] & flag_next);
         end
      end
   end

   assign full    = (count_q == CW'(CKPT_DEPTH));
   assign empty   = (count_q == '0);
   assign pop_ok  = ckpt_pop_i & ~restore_i & ~empty;
   // A concurrent pop frees the slot, so a full buffer still accepts push with pop.
   assign push_ok = ckpt_push_i & ~restore_i & (~full | pop_ok);

   // Flag register and checkpoint ring; restore rewinds the tail and drops younger entries.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         flag_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned k = 0; k < CKPT_DEPTH; k++) begin
            ckpt_q[k] <= '0;
         end
      end else begin
         flag_q <= restore_i ? ckpt_q[restore_id_i] : flag_next;
         if (push_ok) begin
            ckpt_q[tail_q] <= flag_next;
         end
         if (restore_i) begin
            tail_q  <= restore_id_i + IW'(1);
            count_q <= CW'(IW'(restore_id_i - head_q)) + CW'(1);
         end else begin
            if (push_ok) begin
               tail_q <= tail_q + IW'(1);
            end
            if (pop_ok) begin
               head_q <= head_q + IW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
         end
      end
   end

   assign flag_o       = flag_q;
   assign ckpt_id_o    = tail_q;
   assign ckpt_full_o  = full;
   assign ckpt_empty_o = empty;

endmodule

// File: tb/tb_phys_regfile_ckpt.sv
// Directed self-checking bench for phys_regfile_ckpt: reset state, write/clear priority,
// flag merging and checkpoint push/pop/restore.
module tb_phys_regfile_ckpt;

   localparam int unsigned NPR = 128;
   localparam int unsigned NAR = 16;
   localparam int unsigned W   = 16;
   localparam int unsigned NW  = 4;
   localparam int unsigned NR  = 4;
   localparam int unsigned NC  = 2;
   localparam int unsigned NF  = 4;
   localparam int unsigned CD  = 4;
   localparam int unsigned AW  = $clog2(NPR);
   localparam int unsigned IW  = $clog2(CD);

   logic              clk = 1'b0;
   logic              reset;
   logic [NW-1:0]     wr_v;
   logic [NW*AW-1:0]  wr_addr;
   logic [NW*W-1:0]   wr_data;
   logic [NW-1:0]     flag_w_v;
   logic [NW*2*NF-1:0] flag_w;
   logic [NC-1:0]     clr_v;
   logic [NC*AW-1:0]  clr_addr;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR-1:0]     rd_valid;
   logic [NR*W-1:0]   rd_data;
   logic [NF-1:0]     flag;
   logic              ckpt_push;
   logic [IW-1:0]     ckpt_id;
   logic              ckpt_pop;
   logic              restore;
   logic [IW-1:0]     restore_id;
   logic              ckpt_full;
   logic              ckpt_empty;

   int n_checks = 0;
   int n_errors = 0;

   phys_regfile_ckpt #(
      .NUM_PHYS_REG(NPR), .NUM_ARCH_REG(NAR), .WORD_W(W), .NUM_WR(NW),
      .NUM_RD(NR), .NUM_CLR(NC), .NUM_FLAGS(NF), .CKPT_DEPTH(CD)
   ) dut (
      .clk_i(clk), .reset_i(reset),
      .wr_v_i(wr_v), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .flag_w_v_i(flag_w_v), .flag_w_i(flag_w),
      .clr_v_i(clr_v), .clr_addr_i(clr_addr),
      .rd_addr_i(rd_addr), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
      .flag_o(flag),
      .ckpt_push_i(ckpt_push), .ckpt_id_o(ckpt_id), .ckpt_pop_i(ckpt_pop),
      .restore_i(restore), .restore_id_i(restore_id),
      .ckpt_full_o(ckpt_full), .ckpt_empty_o(ckpt_empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_v = '0; wr_addr = '0; wr_data = '0;
      flag_w_v = '0; flag_w = '0;
      clr_v = '0; clr_addr = '0;
      ckpt_push = 1'b0; ckpt_pop = 1'b0;
      restore = 1'b0; restore_id = '0;
   endtask

   task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
      wr_v[p] = 1'b1;
      wr_addr[p*AW +: AW] = a;
      wr_data[p*W +: W] = d;
   endtask

   task automatic set_flag(input int p, input logic [NF-1:0] mask, input logic [NF-1:0] val);
      flag_w_v[p] = 1'b1;
      flag_w[p*2*NF +: 2*NF] = {mask, val};
   endtask

   task automatic set_rd(input int p, input logic [AW-1:0] a);
      rd_addr[p*AW +: AW] = a;
   endtask

   // Restoring a checkpoint that is not live is illegal; head/count are tracked by the bench.
   task automatic do_restore(input logic [IW-1:0] id, input logic [IW-1:0] head, input int cnt);
      assert (int'(IW'(id - head)) < cnt) else $error("restore_id %0d not live", id);
      restore = 1'b1;
      restore_id = id;
   endtask

   initial begin
      idle();
      rd_addr = '0;
      reset = 1'b1;
      set_wr(0, 7'd3, 16'hFFFF);
      tick();
      tick();
      reset = 1'b0;
      idle();

      // Reset state
      set_rd(0, 7'd0); set_rd(1, 7'd15); set_rd(2, 7'd16); set_rd(3, 7'd3);
      #1;
      check("rst_valid0", 32'(rd_valid[0]), 32'd1);
      check("rst_valid15", 32'(rd_valid[1]), 32'd1);
      check("rst_valid16", 32'(rd_valid[2]), 32'd0);
      check("rst_data3", 32'(rd_data[3*W +: W]), 32'h0);
      check("rst_data15", 32'(rd_data[1*W +: W]), 32'h0);
      check("rst_flag", 32'(flag), 32'h0);
      check("rst_empty", 32'(ckpt_empty), 32'd1);
      check("rst_full", 32'(ckpt_full), 32'd0);
      check("rst_id", 32'(ckpt_id), 32'd0);

      // Two ports to the same register: port 3 wins
      set_wr(0, 7'd20, 16'h1111);
      set_wr(3, 7'd20, 16'h3333);
      set_rd(0, 7'd20);
      #1;
`ifdef ARCH_STATE_FWD_EN
      check("fwd_valid20", 32'(rd_valid[0]), 32'd1);
      check("fwd_data20", 32'(rd_data[0 +: W]), 32'h3333);
`else
      check("nofwd_valid20", 32'(rd_valid[0]), 32'd0);
      check("nofwd_data20", 32'(rd_data[0 +: W]), 32'h0);
`endif
      tick();
      idle();
      #1;
      check("wr_valid20", 32'(rd_valid[0]), 32'd1);
      check("wr_data20", 32'(rd_data[0 +: W]), 32'h3333);

      // Clear beats write on the same register; a clear alone keeps data
      set_wr(1, 7'd30, 16'hABCD);
      clr_v[0] = 1'b1; clr_addr[0 +: AW] = 7'd30;
      set_wr(2, 7'd5, 16'h0505);
      tick();
      idle();
      clr_v[1] = 1'b1; clr_addr[AW +: AW] = 7'd5;
      set_rd(1, 7'd30); set_rd(2, 7'd5);
      tick();
      idle();
      #1;
      check("clr_valid30", 32'(rd_valid[1]), 32'd0);
      check("clr_data30", 32'(rd_data[1*W +: W]), 32'hABCD);
      check("clr_valid5", 32'(rd_valid[2]), 32'd0);
      check("clr_data5", 32'(rd_data[2*W +: W]), 32'h0505);
      check("keep_valid20", 32'(rd_valid[0]), 32'd1);

      // Masked flag merge: 0000 -> 0001 (FU1) -> 0011 (FU2 sets bit 1, keeps bit 0)
      set_flag(1, 4'b0011, 4'b0001);
      set_flag(2, 4'b0010, 4'b0010);
      tick();
      idle();
      check("flag_merge", 32'(flag), 32'b0011);

      // Fill the checkpoint ring; pushed value is the post-update flag
      ckpt_push = 1'b1;
      tick();
      check("push0_id", 32'(ckpt_id), 32'd1);
      check("push0_empty", 32'(ckpt_empty), 32'd0);
      set_flag(0, 4'b1111, 4'b0101);
      tick();
      idle();
      check("push1_flag", 32'(flag), 32'b0101);
      ckpt_push = 1'b1;
      set_flag(0, 4'b1111, 4'b1111);
      tick();
      idle();
      ckpt_push = 1'b1;
      tick();
      check("push3_full", 32'(ckpt_full), 32'd1);
      check("push3_id", 32'(ckpt_id), 32'd0);
      tick();
      idle();
      check("push4_ign_id", 32'(ckpt_id), 32'd0);
      check("push4_ign_full", 32'(ckpt_full), 32'd1);
      check("flag_1111", 32'(flag), 32'b1111);

      // Restore id 1 overrides FU flag writes and ignores a same-cycle push
      do_restore(2'd1, 2'd0, 4);
      ckpt_push = 1'b1;
      set_flag(0, 4'b1111, 4'b0000);
      tick();
      idle();
      check("rest_flag", 32'(flag), 32'b0101);
      check("rest_id", 32'(ckpt_id), 32'd2);
      check("rest_full", 32'(ckpt_full), 32'd0);
      check("rest_empty", 32'(ckpt_empty), 32'd0);
      // Count is 2: exactly two more pushes fill the ring
      ckpt_push = 1'b1;
      tick();
      check("rc3_full", 32'(ckpt_full), 32'd0);
      check("rc3_id", 32'(ckpt_id), 32'd3);
      tick();
      check("rc4_full", 32'(ckpt_full), 32'd1);
      check("rc4_id", 32'(ckpt_id), 32'd0);

      // Pop and push together on a full ring keep it full
      ckpt_pop = 1'b1;
      tick();
      idle();
      check("pp_full", 32'(ckpt_full), 32'd1);
      check("pp_id", 32'(ckpt_id), 32'd1);

      // Drain to empty; pop on empty is ignored
      ckpt_pop = 1'b1;
      tick();
      check("pop1_full", 32'(ckpt_full), 32'd0);
      tick();
      tick();
      check("pop3_empty", 32'(ckpt_empty), 32'd0);
      tick();
      check("pop4_empty", 32'(ckpt_empty), 32'd1);
      tick();
      idle();
      check("popE_empty", 32'(ckpt_empty), 32'd1);
      check("popE_id", 32'(ckpt_id), 32'd1);
      ckpt_push = 1'b1;
      tick();
      idle();
      check("repush_empty", 32'(ckpt_empty), 32'd0);
      check("repush_id", 32'(ckpt_id), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
